// File: rtl/packet_playback_sched_pkg.sv
// Shared constants and types for the packet playback descriptor scheduler.
package packet_playback_sched_pkg;

  // Width of one word on the 16-bit configuration daisy chain.
  localparam int CFG_W  = 16;

  // Default descriptor width; matches the player packet_in width.
  localparam int DESC_W = 32;

  // Scheduler sequencing: arbitrate, wait for RAM data, deliver.
  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DELIVER = 2'd2
  } state_t;

endpackage : packet_playback_sched_pkg

// File: rtl/packet_playback_sched_rr_arbiter.sv
// N-way round-robin pick: first ready requester at or after the one-hot
// priority position, wrapping past the top index back to zero.
module packet_playback_sched_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] ready,
  input  logic [N-1:0] prio,
  output logic [N-1:0] grant,
  output logic         any
);

  logic [2*N-1:0] dbl_ready;
  logic [2*N-1:0] dbl_grant;

  // Doubling the request vector turns the wrap-around search into a plain
  // lowest-set-bit-at-or-above-prio search; subtracting prio clears it.
  always_comb begin
    dbl_ready = {ready, ready};
    dbl_grant = dbl_ready & ~(dbl_ready - {{N{1'b0}}, prio});
    grant     = dbl_grant[N-1:0] | dbl_grant[2*N-1:N];
    any       = |ready;
  end

endmodule : packet_playback_sched_rr_arbiter

// File: rtl/packet_playback_sched.sv
// Shared-memory descriptor scheduler: serves NPLAYERS packet players from one
// single-ported descriptor RAM, each player walking its own [start, end)
// window, with round-robin arbitration and one delivery per three cycles.
module packet_playback_sched
  import packet_playback_sched_pkg::*;
#(
  parameter int NPLAYERS = 4,
  parameter int AW       = 10,
  parameter int DW       = DESC_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   error,
  output logic                   is_quiescent,
  output logic                   done,
  input  logic [CFG_W-1:0]       config_in,
  input  logic                   config_in_valid,
  output logic [CFG_W-1:0]       config_out,
  output logic                   config_out_valid,
  output logic [AW-1:0]          mem_addr,
  output logic                   mem_rd_en,
  input  logic [DW-1:0]          mem_rdata,
  input  logic [NPLAYERS-1:0]    packet_request,
  output logic [NPLAYERS*DW-1:0] packet_out,
  output logic [NPLAYERS-1:0]    packet_out_valid
);

  localparam int IW   = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1;
  localparam int NCFG = 2 * NPLAYERS;

  logic [CFG_W-1:0]    cfg     [NCFG];
  logic [AW-1:0]       ptr     [NPLAYERS];
  logic [AW-1:0]       win_end [NPLAYERS];
  logic [DW-1:0]       pkt_q   [NPLAYERS];

  logic [NPLAYERS-1:0] holdoff;
  logic [NPLAYERS-1:0] eligible;
  logic [NPLAYERS-1:0] rr_prio;
  logic [NPLAYERS-1:0] arb_grant;
  logic [NPLAYERS-1:0] grant_q;
  logic                arb_any;
  logic [IW-1:0]       arb_idx;
  logic [IW-1:0]       gidx_q;
  logic                launch;
  logic                deliver;
  state_t              state;

  // Next round-robin priority: one position past the player just served.
  function automatic logic [NPLAYERS-1:0] rotl1(input logic [NPLAYERS-1:0] v);
    return {v[NPLAYERS-2:0], v[NPLAYERS-1]};
  endfunction

  // Window end per player, eligibility and the all-windows-exhausted flag.
  always_comb begin
    done     = 1'b1;
    eligible = '0;
    for (int i = 0; i < NPLAYERS; i++) begin
      win_end[i]  = cfg[2*i][AW-1:0];
      eligible[i] = packet_request[i] & (ptr[i] != win_end[i]) & ~holdoff[i];
      if (ptr[i] != win_end[i]) done = 1'b0;
    end
  end

  packet_playback_sched_rr_arbiter #(
    .N (NPLAYERS)
  ) u_arb (
    .ready (eligible),
    .prio  (rr_prio),
    .grant (arb_grant),
    .any   (arb_any)
  );

  // Binary index of the one-hot arbiter pick, used to address ptr[].
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NPLAYERS; i++) begin
      if (arb_grant[i]) arb_idx = IW'(i);
    end
  end

  // The RAM returns data one cycle after the strobe and WAIT must capture it,
  // so the read strobe is decoded straight from the ARB-state grant decision.
  always_comb begin
    launch           = (state == ST_ARB) & enable & arb_any;
    deliver          = (state == ST_DELIVER) & enable;
    mem_rd_en        = launch;
    mem_addr         = launch ? ptr[arb_idx] : '0;
    is_quiescent     = (state == ST_ARB) & ~(|eligible);
    packet_out_valid = deliver ? grant_q : '0;
    config_out       = cfg[NCFG-1];
  end

  // Config daisy chain: shifts one word per config_in_valid, independent of enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NCFG; k++) cfg[k] <= '0;
    end else if (config_in_valid) begin
      cfg[0] <= config_in;
      for (int k = 1; k < NCFG; k++) cfg[k] <= cfg[k-1];
    end
  end

  // Read pointers: reload with the start word entering cfg[2i+1] on a shift,
  // otherwise advance (mod 2^AW) on each delivery to that player.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NPLAYERS; i++) ptr[i] <= '0;
    end else begin
      for (int i = 0; i < NPLAYERS; i++) begin
        if (config_in_valid)
          ptr[i] <= cfg[2*i][AW-1:0];
        else if (deliver && (gidx_q == IW'(i)))
          ptr[i] <= ptr[i] + 1'b1;
      end
    end
  end

  // Holdoff blocks a player for exactly the cycle after its delivery.
  always_ff @(posedge clock) begin
    if (reset) holdoff <= '0;
    else       holdoff <= deliver ? grant_q : '0;
  end

  // Per-player descriptor registers: WAIT captures RAM data for the grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NPLAYERS; i++) pkt_q[i] <= '0;
    end else if (state == ST_WAIT) begin
      pkt_q[gidx_q] <= mem_rdata;
    end
  end

  // Flatten the per-player descriptor registers onto the packet bus.
  always_comb begin
    packet_out = '0;
    for (int i = 0; i < NPLAYERS; i++) packet_out[i*DW +: DW] = pkt_q[i];
  end

  // Scheduler FSM plus sticky config-while-busy error and chain valid delay.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_ARB;
      rr_prio          <= NPLAYERS'(1);
      grant_q          <= '0;
      gidx_q           <= '0;
      error            <= 1'b0;
      config_out_valid <= 1'b0;
    end else begin
      config_out_valid <= config_in_valid;
      if (config_in_valid && (state != ST_ARB)) error <= 1'b1;
      case (state)
        ST_ARB: begin
          if (launch) begin
            grant_q <= arb_grant;
            gidx_q  <= arb_idx;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          state <= ST_DELIVER;
        end
        ST_DELIVER: begin
          if (enable) begin
            rr_prio <= rotl1(grant_q);
            state   <= ST_ARB;
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule : packet_playback_sched

// File: tb/tb_packet_playback_sched.sv
// Scoreboard bench for packet_playback_sched: expected deliveries are queued
// when stimulus is applied and compared against the delivery monitor.
module tb_packet_playback_sched;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic            error;
  logic            is_quiescent;
  logic            done;
  logic [15:0]     config_in;
  logic            config_in_valid;
  logic [15:0]     config_out;
  logic            config_out_valid;
  logic [AW-1:0]   mem_addr;
  logic            mem_rd_en;
  logic [DW-1:0]   mem_rdata = '0;
  logic [N-1:0]    packet_request;
  logic [N*DW-1:0] packet_out;
  logic [N-1:0]    packet_out_valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct { int player; logic [DW-1:0] data; int cyc; } obs_t;
  typedef struct { int player; logic [DW-1:0] data; } exp_t;
  obs_t obs_q[$];
  exp_t exp_q[$];

  always #5 clock = ~clock;

  packet_playback_sched #(.NPLAYERS(N), .AW(AW), .DW(DW)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .error            (error),
    .is_quiescent     (is_quiescent),
    .done             (done),
    .config_in        (config_in),
    .config_in_valid  (config_in_valid),
    .config_out       (config_out),
    .config_out_valid (config_out_valid),
    .mem_addr         (mem_addr),
    .mem_rd_en        (mem_rd_en),
    .mem_rdata        (mem_rdata),
    .packet_request   (packet_request),
    .packet_out       (packet_out),
    .packet_out_valid (packet_out_valid)
  );

  // RAM model: word content equals its address, one-cycle read latency.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rdata <= {{(DW-AW){1'b0}}, mem_addr};
  end

  // Delivery monitor, sampled on the falling edge.
  always @(negedge clock) begin
    obs_t o;
    cyc = cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (packet_out_valid[i] === 1'b1) begin
        o.player = i;
        o.data   = packet_out[i*DW +: DW];
        o.cyc    = cyc;
        obs_q.push_back(o);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_exp(input int p, input logic [DW-1:0] d);
    exp_t e;
    e.player = p;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    enable          = 1'b1;
    packet_request  = '0;
    config_in       = '0;
    config_in_valid = 1'b0;
    step(2);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic shift_word(input logic [15:0] w);
    config_in       = w;
    config_in_valid = 1'b1;
    step(1);
    config_in_valid = 1'b0;
  endtask

  // First word shifted ends deepest in the chain (start of the last player).
  task automatic load_windows(input logic [15:0] s0, e0, s1, e1, s2, e2, s3, e3);
    shift_word(s3); shift_word(e3);
    shift_word(s2); shift_word(e2);
    shift_word(s1); shift_word(e1);
    shift_word(s0); shift_word(e0);
  endtask

  task automatic wait_obs(input int n, input int budget, input string name);
    for (int k = 0; k < budget && obs_q.size() < n; k++) step(1);
    checks++;
    if (obs_q.size() < n) begin
      failures++;
      $display("FAIL %s timeout: deliveries=%0d required=%0d", name, obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (done !== 1'b1 || is_quiescent !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags: done=%b quiescent=%b required 1 1", done, is_quiescent);
    end
    checks++;
    if (error !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== '0 || packet_out_valid !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: error=%b rd_en=%b addr=%h valid=%b required all 0",
               error, mem_rd_en, mem_addr, packet_out_valid);
    end
    checks++;
    if (packet_out !== '0 || config_out !== 16'h0 || config_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: packet_out=%h config_out=%h cov=%b required 0",
               packet_out, config_out, config_out_valid);
    end
  endtask

  task automatic test_round_robin();
    int c0;
    int n;
    exp_t e;
    do_reset();
    load_windows(16'h000, 16'h003, 16'h010, 16'h012, 16'h0, 16'h0, 16'h0, 16'h0);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL rr_done_loaded: done=%b required 0", done);
    end
    push_exp(0, 32'h0);  push_exp(1, 32'h10);
    push_exp(0, 32'h1);  push_exp(1, 32'h11);
    push_exp(0, 32'h2);
    c0 = cyc;
    packet_request = 4'hF;
    wait_obs(5, 40, "rr");
    step(6);
    n = obs_q.size();
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL rr_count: deliveries=%0d required=5", n);
    end
    for (int k = 0; k < 5 && k < n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q[k].player != e.player || obs_q[k].data !== e.data) begin
        failures++;
        $display("FAIL rr_deliv%0d: player=%0d data=%h required player=%0d data=%h",
                 k, obs_q[k].player, obs_q[k].data, e.player, e.data);
      end
      if (k > 0) begin
        checks++;
        if (obs_q[k].cyc - obs_q[k-1].cyc != 3) begin
          failures++;
          $display("FAIL rr_spacing%0d: gap=%0d required=3", k, obs_q[k].cyc - obs_q[k-1].cyc);
        end
      end
    end
    if (n > 0) begin
      checks++;
      if (obs_q[0].cyc != c0 + 3) begin
        failures++;
        $display("FAIL rr_latency: cycle=%0d required=%0d", obs_q[0].cyc, c0 + 3);
      end
    end
    checks++;
    if (done !== 1'b1 || is_quiescent !== 1'b1) begin
      failures++;
      $display("FAIL rr_end_flags: done=%b quiescent=%b required 1 1", done, is_quiescent);
    end
    checks++;
    if (packet_out[0 +: DW] !== 32'h2 || packet_out[DW +: DW] !== 32'h11) begin
      failures++;
      $display("FAIL rr_hold: p0=%h p1=%h required p0=2 p1=11",
               packet_out[0 +: DW], packet_out[DW +: DW]);
    end
  endtask

  task automatic test_wrap();
    int n;
    exp_t e;
    do_reset();
    load_windows(16'h0, 16'h0, 16'h0, 16'h0, 16'h3FE, 16'h001, 16'h0, 16'h0);
    push_exp(2, 32'h3FE); push_exp(2, 32'h3FF); push_exp(2, 32'h000);
    packet_request = 4'b0100;
    wait_obs(3, 40, "wrap");
    step(10);
    n = obs_q.size();
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL wrap_count: deliveries=%0d required=3", n);
    end
    for (int k = 0; k < 3 && k < n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q[k].player != e.player || obs_q[k].data !== e.data) begin
        failures++;
        $display("FAIL wrap_deliv%0d: player=%0d data=%h required player=%0d data=%h",
                 k, obs_q[k].player, obs_q[k].data, e.player, e.data);
      end
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL wrap_done: done=%b required 1", done);
    end
  endtask

  task automatic test_holdoff();
    int n;
    exp_t e;
    do_reset();
    load_windows(16'h0, 16'h0, 16'h020, 16'h024, 16'h0, 16'h0, 16'h0, 16'h0);
    for (int k = 0; k < 4; k++) push_exp(1, 32'h20 + k);
    packet_request = 4'b0010;
    wait_obs(4, 40, "holdoff");
    n = obs_q.size();
    for (int k = 0; k < 4 && k < n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q[k].player != e.player || obs_q[k].data !== e.data) begin
        failures++;
        $display("FAIL hold_deliv%0d: player=%0d data=%h required player=%0d data=%h",
                 k, obs_q[k].player, obs_q[k].data, e.player, e.data);
      end
      if (k > 0) begin
        checks++;
        if (obs_q[k].cyc - obs_q[k-1].cyc != 4) begin
          failures++;
          $display("FAIL hold_spacing%0d: gap=%0d required=4", k, obs_q[k].cyc - obs_q[k-1].cyc);
        end
      end
    end
  endtask

  task automatic test_enable_gap();
    int gate_cyc;
    do_reset();
    load_windows(16'h040, 16'h041, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    packet_request = 4'b0001;
    step(1);
    enable = 1'b0;
    step(6);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL gap_no_pulse: deliveries=%0d required=0", obs_q.size());
    end
    gate_cyc = cyc;
    enable   = 1'b1;
    step(3);
    checks++;
    if (obs_q.size() != 1) begin
      failures++;
      $display("FAIL gap_count: deliveries=%0d required=1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].player != 0 || obs_q[0].data !== 32'h40 || obs_q[0].cyc != gate_cyc + 1) begin
        failures++;
        $display("FAIL gap_deliv: player=%0d data=%h cycle=%0d required player=0 data=40 cycle=%0d",
                 obs_q[0].player, obs_q[0].data, obs_q[0].cyc, gate_cyc + 1);
      end
    end
  endtask

  task automatic test_config_error();
    do_reset();
    load_windows(16'h050, 16'h052, 16'h0, 16'h0, 16'h0, 16'h0, 16'hA0C5, 16'hB0C5);
    checks++;
    if (config_out !== 16'hA0C5 || error !== 1'b0) begin
      failures++;
      $display("FAIL cfg_loaded: config_out=%h error=%b required A0C5 0", config_out, error);
    end
    packet_request = 4'b0001;
    step(1);
    config_in       = 16'h1234;
    config_in_valid = 1'b1;
    step(1);
    config_in_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || config_out !== 16'hB0C5 || config_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL cfg_busy_shift: error=%b config_out=%h cov=%b required 1 B0C5 1",
               error, config_out, config_out_valid);
    end
    step(1);
    checks++;
    if (obs_q.size() < 1 || obs_q[0].player != 0 || obs_q[0].data !== 32'h50) begin
      failures++;
      $display("FAIL cfg_pending_deliv: deliveries=%0d required first player=0 data=50", obs_q.size());
    end
    step(12);
    packet_request = '0;
    step(4);
    checks++;
    if (error !== 1'b1) begin
      failures++;
      $display("FAIL cfg_sticky: error=%b required 1", error);
    end
    do_reset();
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL cfg_clear: error=%b required 0", error);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    load_windows(16'h060, 16'h062, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    packet_request = 4'b0001;
    step(1);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_pre: done=%b required 0", done);
    end
    reset = 1'b1;
    step(2);
    reset          = 1'b0;
    packet_request = '0;
    step(5);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL rst_wait_pulse: deliveries=%0d required=0", obs_q.size());
    end
    checks++;
    if (done !== 1'b1 || is_quiescent !== 1'b1 || packet_out !== '0) begin
      failures++;
      $display("FAIL rst_wait_state: done=%b quiescent=%b packet_out=%h required 1 1 0",
               done, is_quiescent, packet_out);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_holdoff();
    test_enable_gap();
    test_config_error();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_packet_playback_sched
